mmio_uart_tx: RTL and testbench
===============================

# mmio_uart_tx

Memory-mapped UART transmitter on the far side of the CPU's byte-store output port (`data_write`, `data`, `data_address`). Byte stores to a fixed TX address are captured into a small FIFO and serialized as 8N1 frames on a single `tx` line. It lets programs running on the pipelined core emit characters without any read path back into the CPU.

## Interface
- `TX_ADDR`, default 32'h0000_FFF0: byte address that selects the TX data register.
- `CLKS_PER_BIT`, default 434: clock cycles per serial bit (50 MHz / 115200); legal range is 2 or more.
- `FIFO_DEPTH`, default 16: byte entries; must be a power of two and at least 2.
- `clk`  in  1  system clock; all state changes on the rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `data_write`  in  1  CPU store strobe, valid for one cycle per store.
- `data`  in  8  store byte.
- `data_address`  in  32  store address.
- `tx`  out  1  serial line; idles high.
- `busy`  out  1  high while the FIFO is non-empty or a frame is in progress.
- `fifo_full`  out  1  FIFO holds `FIFO_DEPTH` entries.
- `dropped_count`  out  16  bytes rejected on overflow. Present only with `MMIO_UART_TX_DROP_CNT_EN`.

## Operation
- **Push.** A push occurs when `data_write` is high and `data_address == TX_ADDR`, using a full 32-bit compare.
  - Stores to any other address are ignored.
- **Acceptance.** A push is accepted if the FIFO is not full, or if a pop happens in the same cycle.
  - When full with a simultaneous pop, the push is accepted and the count is unchanged.
  - Otherwise a push to a full FIFO is dropped, and the stored data is not disturbed.
- **FSM states.** IDLE, START, DATA, STOP.
  - IDLE: `tx`=1. If the FIFO is non-empty, pop its head into the shift register, load the baud counter with `CLKS_PER_BIT-1`, and go to START.
  - START: `tx`=0. When the baud counter reaches 0, reload it, set bit index to 0, and go to DATA.
  - DATA: `tx`=shift[0], sent LSB first. At baud counter 0: shift right and increment the index. After index 7 completes, go to STOP.
  - STOP: `tx`=1. At baud counter 0: if the FIFO is non-empty, pop and go directly to START with no idle cycle; otherwise go to IDLE.
- **Counter widths.** The baud counter is $clog2(`CLKS_PER_BIT`) bits. The bit index is 3 bits. FIFO pointers are $clog2(`FIFO_DEPTH`) bits and wrap naturally. The count is one bit wider than the pointers.
- **`tx` register.** `tx` is registered, so there are no combinational glitches.
- **Reset mid-frame.** Reset aborts the frame, empties the FIFO, forces IDLE, and drives `tx` high from the next edge. A push presented in the reset cycle is ignored.

## Timing
- **Reset values.** `tx`=1, `busy`=0, `fifo_full`=0, `dropped_count`=0.
- **Start latency.** Push sampled at edge k means the FIFO is non-empty after k. With the FSM idle, the pop occurs at edge k+1 and `tx` goes low from edge k+1, giving a 1-cycle start latency.
- **Frame length.** Exactly 10·`CLKS_PER_BIT` cycles: start, 8 data bits, stop, each `CLKS_PER_BIT` cycles.
- **Back-to-back frames.** With the FIFO non-empty, the next start bit begins on the cycle immediately after the stop bit ends.
- **`busy` timing.** `busy` rises at edge k and falls on the same edge the FSM enters IDLE with the FIFO empty.
- **`fifo_full` timing.** `fifo_full` reflects the count after each edge.

## Configuration
- `MMIO_UART_TX_DROP_CNT_EN` defined:
  - `dropped_count` exists and increments by 1 on each rejected push.
  - It saturates at 16'hFFFF.
  - It is cleared only by `reset`.
- `MMIO_UART_TX_DROP_CNT_EN` undefined:
  - The port and counter are absent.
  - Overflow bytes are silently discarded.
  - All other behaviour is identical.

## Structure
- **Package `uart_pkg`.**
  - The `uart_tx_state_t` enum: IDLE, START, DATA, STOP.
  - Constants `UART_TX_ADDR_DEFAULT` (32'h0000_FFF0) and `UART_CLKS_PER_BIT_DEFAULT` (434).
- **Sub-module `byte_fifo`.**
  - Parameterized by depth.
  - Ports: push, pop, push data, head data, full, empty, count.
  - Head data is valid combinationally when non-empty.
- **Top level.** `mmio_uart_tx` holds the address decode, FSM, baud counter, and drop counter.

## Test plan
All scenarios use `CLKS_PER_BIT`=4 and `FIFO_DEPTH`=4.
- **Single byte.** Store 8'hA5 to `TX_ADDR` → `tx` low 4 cycles starting one cycle after the store. Then bits 1,0,1,0,0,1,0,1 at 4 cycles each, then high 4 cycles. `busy` falls after 40 cycles.
- **Address filter.** Store 8'h55 to `TX_ADDR`+4 and to 32'h0 → `tx` stays high and `busy` stays 0.
- **Back-to-back.** Store 8'h00 then 8'hFF on consecutive cycles → two frames with no idle gap, 80 cycles total. The second start bit directly follows the first stop bit.
- **Overflow.** While frame 1 is active, store 6 bytes (8'h01–8'h06) → bytes 01–05 are transmitted in order. Byte 06 is dropped, `fifo_full` is high after the 5th store, and with the macro defined `dropped_count`=1.
- **Full with simultaneous pop.** With the FIFO full and the FSM in STOP at baud count 0, store 8'h7E in that cycle → the byte is accepted and later transmitted, and `dropped_count` is unchanged.
- **Reset mid-frame.** Queue 3 bytes, assert `reset` during DATA bit 3 → `tx`=1 the next cycle, `busy`=0, and no further frames appear after reset is released.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared types and default constants for the memory-mapped UART transmitter.
package uart_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } uart_tx_state_t;

  localparam logic [31:0] UART_TX_ADDR_DEFAULT      = 32'h0000_FFF0;
  localparam int          UART_CLKS_PER_BIT_DEFAULT = 434;
  localparam int          UART_FIFO_DEPTH_DEFAULT   = 16;

endpackage

// File: rtl/byte_fifo.sv
// Byte FIFO with combinational head read; a push while full is taken only
// when a pop happens in the same cycle.
module byte_fifo #(
  parameter  int DEPTH = 16,
  localparam int PTR_W = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic             pop,
  input  logic [7:0]       push_data,
  output logic [7:0]       head_data,
  output logic             full,
  output logic             empty,
  output logic [PTR_W:0]   count
);

  logic [7:0]       mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q;
  logic [PTR_W-1:0] rd_ptr_q;
  logic [PTR_W:0]   count_q;
  logic             push_ok;
  logic             pop_ok;

  assign full      = (count_q == (PTR_W+1)'(DEPTH));
  assign empty     = (count_q == '0);
  assign count     = count_q;
  assign head_data = mem_q[rd_ptr_q];

  assign pop_ok  = pop && !empty;
  assign push_ok = push && (!full || pop_ok);

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_ok) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (pop_ok)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      case ({push_ok, pop_ok})
        2'b10:   count_q <= count_q + (PTR_W+1)'(1);
        2'b01:   count_q <= count_q - (PTR_W+1)'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  // Storage has no reset so it can map onto RAM resources.
  always_ff @(posedge clk) begin
    if (push_ok && !reset) mem_q[wr_ptr_q] <= push_data;
  end

endmodule

// File: rtl/mmio_uart_tx.sv
// Memory-mapped 8N1 UART transmitter fed by CPU byte stores to TX_ADDR.
// Define MMIO_UART_TX_DROP_CNT_EN to add the saturating dropped_count output.
module mmio_uart_tx
  import uart_pkg::*;
#(
  parameter logic [31:0] TX_ADDR      = UART_TX_ADDR_DEFAULT,
  parameter int          CLKS_PER_BIT = UART_CLKS_PER_BIT_DEFAULT,
  parameter int          FIFO_DEPTH   = UART_FIFO_DEPTH_DEFAULT
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        data_write,
  input  logic [7:0]  data,
  input  logic [31:0] data_address,
  output logic        tx,
  output logic        busy,
  output logic        fifo_full
`ifdef MMIO_UART_TX_DROP_CNT_EN
  ,
  output logic [15:0] dropped_count
`endif
);

  localparam int BAUD_W = $clog2(CLKS_PER_BIT);
  localparam int PTR_W  = $clog2(FIFO_DEPTH);
  localparam logic [BAUD_W-1:0] BAUD_RELOAD = BAUD_W'(CLKS_PER_BIT - 1);

  uart_tx_state_t    state_q, state_d;
  logic [BAUD_W-1:0] baud_q, baud_d;
  logic [2:0]        idx_q, idx_d;
  logic [7:0]        shift_q, shift_d;
  logic              tx_q, tx_d;
  logic              busy_d;
  logic              push;
  logic              pop;
  logic              fifo_empty;
  logic              fifo_full_w;
  logic [7:0]        head_data;
  logic [PTR_W:0]    fifo_count;

  assign push = data_write && (data_address == TX_ADDR);

  byte_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (push),
    .pop       (pop),
    .push_data (data),
    .head_data (head_data),
    .full      (fifo_full_w),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      baud_q  <= '0;
      idx_q   <= '0;
      shift_q <= '0;
      tx_q    <= 1'b1;
    end else begin
      state_q <= state_d;
      baud_q  <= baud_d;
      idx_q   <= idx_d;
      shift_q <= shift_d;
      tx_q    <= tx_d;
    end
  end

  always_comb begin
    state_d = state_q;
    baud_d  = baud_q;
    idx_d   = idx_q;
    shift_d = shift_q;
    pop     = 1'b0;
    case (state_q)
      IDLE: begin
        if (!fifo_empty) begin
          pop     = 1'b1;
          shift_d = head_data;
          baud_d  = BAUD_RELOAD;
          state_d = START;
        end
      end
      START: begin
        if (baud_q == '0) begin
          baud_d  = BAUD_RELOAD;
          idx_d   = 3'd0;
          state_d = DATA;
        end else begin
          baud_d = baud_q - BAUD_W'(1);
        end
      end
      DATA: begin
        if (baud_q == '0) begin
          baud_d  = BAUD_RELOAD;
          shift_d = shift_q >> 1;
          idx_d   = idx_q + 3'd1;
          if (idx_q == 3'd7) state_d = STOP;
        end else begin
          baud_d = baud_q - BAUD_W'(1);
        end
      end
      STOP: begin
        if (baud_q == '0) begin
          // Chain straight into the next start bit when more data is queued.
          if (!fifo_empty) begin
            pop     = 1'b1;
            shift_d = head_data;
            baud_d  = BAUD_RELOAD;
            state_d = START;
          end else begin
            state_d = IDLE;
          end
        end else begin
          baud_d = baud_q - BAUD_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    tx_d = 1'b1;
    case (state_d)
      START:   tx_d = 1'b0;
      DATA:    tx_d = shift_d[0];
      default: tx_d = 1'b1;
    endcase
    busy_d = (state_q != IDLE) || (fifo_count != '0);
  end

  assign tx        = tx_q;
  assign busy      = busy_d;
  assign fifo_full = fifo_full_w;

`ifdef MMIO_UART_TX_DROP_CNT_EN
  logic        drop;
  logic [15:0] drop_cnt_q;

  assign drop = push && fifo_full_w && !pop;

  always_ff @(posedge clk) begin
    if (reset) begin
      drop_cnt_q <= '0;
    end else if (drop && (drop_cnt_q != 16'hFFFF)) begin
      drop_cnt_q <= drop_cnt_q + 16'd1;
    end
  end

  assign dropped_count = drop_cnt_q;
`endif

endmodule

// File: tb/tb_mmio_uart_tx.sv
// Self-checking bench for mmio_uart_tx: cycle-stepped frame-position reference
// model compared against tx, busy, fifo_full (and dropped_count when enabled).
module tb_mmio_uart_tx;

  localparam logic [31:0] TXA   = 32'h0000_FFF0;
  localparam int          CPB   = 4;
  localparam int          DEPTH = 4;
  localparam int          FRAME = 10 * CPB;

  logic        clk = 1'b0;
  logic        reset;
  logic        data_write;
  logic [7:0]  data;
  logic [31:0] data_address;
  logic        tx;
  logic        busy;
  logic        fifo_full;
`ifdef MMIO_UART_TX_DROP_CNT_EN
  logic [15:0] dropped_count;
`endif

  always #5 clk = ~clk;

  mmio_uart_tx #(
    .TX_ADDR      (TXA),
    .CLKS_PER_BIT (CPB),
    .FIFO_DEPTH   (DEPTH)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .data_write   (data_write),
    .data         (data),
    .data_address (data_address),
    .tx           (tx),
    .busy         (busy),
    .fifo_full    (fifo_full)
`ifdef MMIO_UART_TX_DROP_CNT_EN
    ,
    .dropped_count(dropped_count)
`endif
  );

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  // Reference model: queued bytes, and position inside the frame on the line.
  logic [7:0] mq[$];
  bit         m_active = 1'b0;
  int         m_pos    = 0;
  logic [7:0] m_cur    = 8'h00;
  int         m_drops  = 0;

  function automatic logic model_tx();
    int slot;
    if (!m_active) return 1'b1;
    slot = m_pos / CPB;
    if (slot == 0) return 1'b0;
    if (slot == 9) return 1'b1;
    return m_cur[slot-1];
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s cyc=%0d observed=%0h expected=%0h", tag, cyc, obs, exp);
    end
  endtask

  task automatic tick(input logic w, input logic [31:0] a, input logic [7:0] d, input logic r);
    bit push_hit;
    bit pop_m;
    bit acc;
    reset        = r;
    data_write   = w;
    data_address = a;
    data         = d;
    push_hit = w && (a == TXA);
    pop_m    = (mq.size() > 0) && (!m_active || (m_pos == FRAME - 1));
    @(posedge clk);
    cyc++;
    if (r) begin
      mq.delete();
      m_active = 1'b0;
      m_pos    = 0;
      m_drops  = 0;
    end else begin
      acc = push_hit && ((mq.size() < DEPTH) || pop_m);
      if (m_active) begin
        m_pos++;
        if (m_pos == FRAME) m_active = 1'b0;
      end
      if (pop_m) begin
        m_cur    = mq.pop_front();
        m_active = 1'b1;
        m_pos    = 0;
      end
      if (acc) mq.push_back(d);
      else if (push_hit && m_drops < 65535) m_drops++;
    end
    #1;
    data_write = 1'b0;
    reset      = 1'b0;
    check("tx", {31'd0, tx}, {31'd0, model_tx()});
    check("busy", {31'd0, busy}, {31'd0, (m_active || mq.size() > 0)});
    check("fifo_full", {31'd0, fifo_full}, {31'd0, (mq.size() == DEPTH)});
`ifdef MMIO_UART_TX_DROP_CNT_EN
    check("dropped_count", {16'd0, dropped_count}, 32'(m_drops));
`endif
  endtask

  task automatic store(input logic [31:0] a, input logic [7:0] d);
    $display("store cyc=%0d addr=%08h data=%02h", cyc, a, d);
    tick(1'b1, a, d, 1'b0);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick(1'b0, 32'h0, 8'h00, 1'b0);
  endtask

  initial begin
    bit found;
    reset        = 1'b1;
    data_write   = 1'b0;
    data         = 8'h00;
    data_address = 32'h0;
    tick(1'b0, 32'h0, 8'h00, 1'b1);
    tick(1'b0, 32'h0, 8'h00, 1'b1);
    idle(2);

    // Single byte
    store(TXA, 8'hA5);
    idle(FRAME + 5);

    // Address filter
    store(TXA + 32'd4, 8'h55);
    store(32'h0, 8'h55);
    idle(8);

    // Back-to-back frames
    store(TXA, 8'h00);
    store(TXA, 8'hFF);
    idle(2 * FRAME + 5);

    // Overflow: sixth byte is rejected
    for (int i = 1; i <= 6; i++) store(TXA, 8'(i));
    idle(5 * FRAME + 5);

    // Full FIFO with a push on the same edge as the chaining pop
    for (int i = 0; i < 5; i++) store(TXA, 8'h11 + 8'(i));
    found = 1'b0;
    for (int i = 0; i < 200 && !found; i++) begin
      if (m_active && m_pos == FRAME - 1 && mq.size() == DEPTH) found = 1'b1;
      else idle(1);
    end
    check("full_pop_window_found", {31'd0, found}, 32'd1);
    if (found) store(TXA, 8'h7E);
    idle(5 * FRAME + 5);

    // Reset during DATA bit 3, with a push in the reset cycle
    for (int i = 0; i < 3; i++) store(TXA, 8'hC0 + 8'(i));
    found = 1'b0;
    for (int i = 0; i < 200 && !found; i++) begin
      if (m_active && (m_pos / CPB) == 4) found = 1'b1;
      else idle(1);
    end
    check("mid_frame_window_found", {31'd0, found}, 32'd1);
    $display("reset cyc=%0d during data bit 3", cyc);
    tick(1'b1, TXA, 8'h99, 1'b1);
    idle(FRAME + 20);

    // Randomised traffic
    for (int i = 0; i < 400; i++) begin
      logic        r;
      logic        w;
      logic [31:0] a;
      logic [7:0]  d;
      r = ($urandom_range(0, 199) == 0);
      w = ($urandom_range(0, 2) == 0);
      case ($urandom_range(0, 3))
        0:       a = TXA + 32'd4;
        1:       a = $urandom;
        default: a = TXA;
      endcase
      d = 8'($urandom);
      if (w || r) $display("rand cyc=%0d we=%0d rst=%0d addr=%08h data=%02h", cyc, w, r, a, d);
      tick(w, a, d, r);
    end
    idle((DEPTH + 1) * FRAME + 10);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
